// File: rtl/pulse_tracer_pkg.sv
// Shared edge-mode encodings and sizing helpers for the multi-channel pulse tracer.
package pulse_tracer_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  // Run counter must hold FILTER_LEN-1; never narrower than one bit.
  function automatic int run_width(input int filter_len);
    return (filter_len < 2) ? 1 : $clog2(filter_len);
  endfunction

endpackage

// File: rtl/pulse_tracer_chan.sv
// One tracer channel: synchroniser, stability filter, edge-mode select and
// saturating event counter.
module pulse_tracer_chan
  import pulse_tracer_pkg::*;
#(
  parameter int FILTER_LEN  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             noisy_in,
  input  logic [1:0]       edge_mode,
  input  logic             count_clr,
  output logic             level_out,
  output logic             pulse_out,
  output logic [CNT_W-1:0] event_count
);

  localparam int RUN_W = run_width(FILTER_LEN);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sample;
  logic                   level_p1;
  logic [RUN_W-1:0]       run_p1;
  logic                   pulse_p1;
  logic [CNT_W-1:0]       cnt_p2;
  logic                   accept;

  function automatic logic edge_match(input logic [1:0] mode, input logic rising);
    case (mode)
      EDGE_RISE: return rising;
      EDGE_FALL: return !rising;
      EDGE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
  endfunction

  assign sample = sync_p0[SYNC_STAGES-1];
  assign accept = (sample != level_p1) && (run_p1 == RUN_LAST);

  // Stage p0: synchroniser shift chain (shift form works for a single stage too)
  always_ff @(posedge clk) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= (sync_p0 << 1) | SYNC_STAGES'(noisy_in);
  end

  // Stage p1: stability filter and edge pulse; a matching sample restarts the run
  always_ff @(posedge clk) begin
    if (rst) begin
      level_p1 <= 1'b0;
      run_p1   <= '0;
      pulse_p1 <= 1'b0;
    end else begin
      if (sample == level_p1) begin
        run_p1 <= '0;
      end else if (accept) begin
        level_p1 <= sample;
        run_p1   <= '0;
      end else begin
        run_p1 <= run_p1 + 1'b1;
      end
      pulse_p1 <= accept && edge_match(edge_mode, sample);
    end
  end

  // Stage p2: event counter; clear wins over a coincident pulse
  always_ff @(posedge clk) begin
    if (rst || count_clr) cnt_p2 <= '0;
    else if (pulse_p1)    cnt_p2 <= sat_inc(cnt_p2);
  end

  assign level_out   = level_p1;
  assign pulse_out   = pulse_p1;
  assign event_count = cnt_p2;

endmodule

// File: rtl/multi_pulse_tracer.sv
// Multi-channel glitch filter / edge tracer: independent channels plus a
// combined any-pulse flag.
module multi_pulse_tracer
  import pulse_tracer_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int FILTER_LEN  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       noisy_in,
  input  logic [1:0]                edge_mode,
  input  logic                      count_clr,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS*CNT_W-1:0] event_count,
  output logic                      any_pulse
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_tracer_chan #(
      .FILTER_LEN (FILTER_LEN),
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .noisy_in   (noisy_in[i]),
      .edge_mode  (edge_mode),
      .count_clr  (count_clr),
      .level_out  (level_out[i]),
      .pulse_out  (pulse_out[i]),
      .event_count(event_count[i*CNT_W +: CNT_W])
    );
  end

  assign any_pulse = |pulse_out;

endmodule

// File: tb/tb_multi_pulse_tracer.sv
// Scoreboard bench for multi_pulse_tracer: stimulus queues expected pulse
// events, a negedge monitor pops and compares whenever a pulse appears.
module tb_multi_pulse_tracer;

  localparam int CH  = 4;
  localparam int FL  = 3;
  localparam int SS  = 2;
  localparam int CW  = 8;
  localparam int LAT = SS + FL;

  logic              clk;
  logic              rst;
  logic [CH-1:0]     noisy_in;
  logic [1:0]        edge_mode;
  logic              count_clr;
  logic [CH-1:0]     level_out;
  logic [CH-1:0]     pulse_out;
  logic [CH*CW-1:0]  event_count;
  logic              any_pulse;

  multi_pulse_tracer #(
    .CHANNELS(CH), .FILTER_LEN(FL), .SYNC_STAGES(SS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .edge_mode(edge_mode),
    .count_clr(count_clr), .level_out(level_out), .pulse_out(pulse_out),
    .event_count(event_count), .any_pulse(any_pulse)
  );

  typedef struct {
    int            cyc;
    logic [CH-1:0] pulse;
    logic [CH-1:0] level;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return event_count[ch*CW +: CW];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at, input logic [CH-1:0] p, input logic [CH-1:0] l);
    exp_t e;
    e.cyc = at; e.pulse = p; e.level = l;
    q.push_back(e);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_level"}, 64'(level_out), 64'd0);
    chk({nm, "_pulse"}, 64'(pulse_out), 64'd0);
    chk({nm, "_count"}, 64'(event_count), 64'd0);
    chk({nm, "_any"},   64'(any_pulse), 64'd0);
  endtask

  // Monitor: every cycle with a pulse must match the head of the queue
  always @(negedge clk) begin
    if (any_pulse || (pulse_out != '0)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 64'(pulse_out), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("pulse_vec",   64'(pulse_out), 64'(e.pulse));
        chk("pulse_level", 64'(level_out), 64'(e.level));
        chk("any_pulse",   64'(any_pulse), 64'd1);
      end
    end
  end

  logic [CH-1:0] lvl;
  int c0;

  initial begin
    rst = 1'b1; noisy_in = '0; edge_mode = 2'b00; count_clr = 1'b0;
    step(3);
    chk_idle("reset");
    rst = 1'b0;

    // Single-cycle glitch is filtered out
    noisy_in[0] = 1'b1; step(1);
    noisy_in[0] = 1'b0; step(8);
    chk("glitch_level", 64'(level_out), 64'd0);
    chk("glitch_cnt0",  64'(cnt_of(0)), 64'd0);

    // Rise mode, held high: exactly one pulse after LAT edges
    edge_mode = 2'b00;
    c0 = cyc; noisy_in[0] = 1'b1;
    expect_pulse(c0 + LAT, 4'b0001, 4'b0001);
    step(13);
    chk("hold_level", 64'(level_out), 64'b0001);
    chk("hold_cnt0",  64'(cnt_of(0)), 64'd1);
    noisy_in[0] = 1'b0; step(8);
    chk("rise_fall_level", 64'(level_out), 64'd0);

    // Both mode on ch1
    edge_mode = 2'b10;
    c0 = cyc; noisy_in[1] = 1'b1;
    expect_pulse(c0 + LAT, 4'b0010, 4'b0010);
    step(6); noisy_in[1] = 1'b0;
    expect_pulse(c0 + 6 + LAT, 4'b0010, 4'b0000);
    step(8);
    chk("both_cnt1", 64'(cnt_of(1)), 64'd2);

    // Fall mode: only the falling accept pulses
    edge_mode = 2'b01;
    c0 = cyc; noisy_in[1] = 1'b1;
    step(6); noisy_in[1] = 1'b0;
    expect_pulse(c0 + 6 + LAT, 4'b0010, 4'b0000);
    step(8);
    chk("fall_cnt1", 64'(cnt_of(1)), 64'd3);

    // None mode: level follows, no pulses
    edge_mode = 2'b11;
    noisy_in[1] = 1'b1; step(6);
    chk("none_level_hi", 64'(level_out), 64'b0010);
    noisy_in[1] = 1'b0; step(8);
    chk("none_level_lo", 64'(level_out), 64'd0);
    chk("none_cnt1",     64'(cnt_of(1)), 64'd3);

    // Sequence 1,0,1,1,1,1: pulse timed from the second rise
    edge_mode = 2'b00;
    c0 = cyc;
    noisy_in[0] = 1'b1; step(1);
    noisy_in[0] = 1'b0; step(1);
    noisy_in[0] = 1'b1;
    expect_pulse(c0 + 2 + LAT, 4'b0001, 4'b0001);
    step(6);
    chk("seq_cnt0", 64'(cnt_of(0)), 64'd2);
    noisy_in[0] = 1'b0; step(8);

    // 300 pulses on ch2 saturate the counter
    edge_mode = 2'b10;
    lvl = '0;
    for (int k = 0; k < 300; k++) begin
      noisy_in[2] = ~noisy_in[2];
      lvl ^= 4'b0100;
      expect_pulse(cyc + LAT, 4'b0100, lvl);
      step(4);
    end
    step(4);
    chk("sat_cnt2", 64'(cnt_of(2)), 64'd255);

    // Clear coincident with a pulse: pulse seen, count zero
    c0 = cyc; noisy_in[2] = 1'b1;
    expect_pulse(c0 + LAT, 4'b0100, 4'b0100);
    step(LAT);
    count_clr = 1'b1; step(1);
    count_clr = 1'b0; step(2);
    chk("clr_cnt2", 64'(cnt_of(2)), 64'd0);
    c0 = cyc; noisy_in[2] = 1'b0;
    expect_pulse(c0 + LAT, 4'b0100, 4'b0000);
    step(8);
    chk("after_clr_cnt2", 64'(cnt_of(2)), 64'd1);

    // Simultaneous accepts on ch2 and ch3
    edge_mode = 2'b00;
    c0 = cyc; noisy_in[3:2] = 2'b11;
    expect_pulse(c0 + LAT, 4'b1100, 4'b1100);
    step(8);
    chk("sim_cnt2", 64'(cnt_of(2)), 64'd2);
    chk("sim_cnt3", 64'(cnt_of(3)), 64'd1);
    noisy_in = '0; step(8);
    chk("sim_level_lo", 64'(level_out), 64'd0);

    // Reset in the middle of a build-up discards it
    noisy_in[3] = 1'b1; step(4);
    rst = 1'b1; noisy_in = '0; step(1);
    chk_idle("midrst_in");
    step(1); rst = 1'b0; step(8);
    chk_idle("midrst_after");

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
